// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with EX/MEM output register (valid/ready),
// iterative multiply/divide with HI/LO, and registered branch resolution.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   ID/EX handshake (in_ready is combinational)
//   rs_data, rt_data,     operands (imm pre-extended by decode)
//   imm, pc4, shamt
//   alu_op, alu_src       ALU function and operand-B select
//   md_op                 mult/div/mfhi/mflo selector
//   branch                beq-type branch request
//   dest_sel, rt_num,     destination register selection
//   rd_num, reg_write_in
//   ctrl_in / ctrl_out    opaque sideband bundle, passed through
//   out_valid / out_ready EX/MEM handshake
//   result, store_data,   registered EX/MEM fields
//   baddr, dest_num,
//   reg_write_out, pc_src, div_by_zero
//   busy                  high while a multiply/divide is iterating
module ex_stage_md #(
    parameter int WIDTH  = 32,
    parameter int REGW   = 5,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  rt_data,
    input  logic [WIDTH-1:0]  imm,
    input  logic [WIDTH-1:0]  pc4,
    input  logic [4:0]        shamt,
    input  logic [3:0]        alu_op,
    input  logic              alu_src,
    input  logic [2:0]        md_op,
    input  logic              branch,
    input  logic [1:0]        dest_sel,
    input  logic [REGW-1:0]   rt_num,
    input  logic [REGW-1:0]   rd_num,
    input  logic              reg_write_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  store_data,
    output logic [WIDTH-1:0]  baddr,
    output logic [REGW-1:0]   dest_num,
    output logic              reg_write_out,
    output logic              pc_src,
    output logic              div_by_zero,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic              busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, MD} state_t;

    state_t state, state_nx;

    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  hi, lo;
    logic [WIDTH-1:0]  acc_hi, acc_lo, mcand;
    logic [WIDTH-1:0]  dvd_raw, md_store;
    logic [REGW-1:0]   md_dest;
    logic [CTRL_W-1:0] md_ctrl;
    logic              md_div, neg_q, neg_r, dz;

    logic slot_free, accept, is_md_op, last, fire;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign is_md_op  = (md_op != 3'd0) && (md_op <= 3'd4);
    assign last      = (state == MD) && (cnt == CW'(WIDTH - 1));
    assign fire      = last && slot_free;
    assign busy      = (state == MD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && is_md_op) state_nx = MD;
            MD:   if (fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ALU path
    logic [WIDTH-1:0] opb, alu_res, ex_res, baddr_nx;
    logic [REGW-1:0]  dest_nx;

    always_comb begin
        opb = alu_src ? imm : rt_data;
        alu_res = '0;
        case (alu_op)
            4'd0:  alu_res = rs_data + opb;
            4'd1:  alu_res = rs_data - opb;
            4'd2:  alu_res = rs_data & opb;
            4'd3:  alu_res = rs_data | opb;
            4'd4:  alu_res = rs_data ^ opb;
            4'd5:  alu_res = ~(rs_data | opb);
            4'd6:  alu_res = {{(WIDTH-1){1'b0}},
                              $signed(rs_data) < $signed(opb)};
            4'd7:  alu_res = {{(WIDTH-1){1'b0}}, rs_data < opb};
            4'd8:  alu_res = opb << shamt;
            4'd9:  alu_res = opb >> shamt;
            4'd10: alu_res = $unsigned($signed(opb) >>> shamt);
            default: alu_res = '0;
        endcase
        if (md_op == 3'd5)      ex_res = hi;
        else if (md_op == 3'd6) ex_res = lo;
        else                    ex_res = alu_res;
        case (dest_sel)
            2'b01:   dest_nx = rd_num;
            2'b10:   dest_nx = '1;
            default: dest_nx = rt_num;
        endcase
        baddr_nx = pc4 + (imm << 2);
    end

    // Operand magnitudes captured at MD accept
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] ma, mb;

    always_comb begin
        sgn = (md_op == 3'd1) || (md_op == 3'd3);
        sa  = sgn && rs_data[WIDTH-1];
        sb  = sgn && rt_data[WIDTH-1];
        ma  = sa ? -rs_data : rs_data;
        mb  = sb ? -rt_data : rt_data;
    end

    // One iteration. acc_hi:acc_lo is the shifting product for
    // multiply, or remainder:quotient for restoring division.
    logic [WIDTH:0]     msum, trial;
    logic [WIDTH-1:0]   hi_st, lo_st, fin_hi, fin_lo;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        msum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, mcand};
        if (md_div) begin
            if (!trial[WIDTH]) begin
                hi_st = trial[WIDTH-1:0];
                lo_st = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_st = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                lo_st = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_st = msum[WIDTH:1];
            lo_st = {msum[0], acc_lo[WIDTH-1:1]};
        end
        prod = {hi_st, lo_st};
        if (neg_q) prod = -prod;
        if (!md_div) begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end else if (dz) begin
            fin_hi = dvd_raw;
            fin_lo = '1;
        end else begin
            fin_hi = neg_r ? -hi_st : hi_st;
            fin_lo = neg_q ? -lo_st : lo_st;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            hi            <= '0;
            lo            <= '0;
            acc_hi        <= '0;
            acc_lo        <= '0;
            mcand         <= '0;
            dvd_raw       <= '0;
            md_store      <= '0;
            md_dest       <= '0;
            md_ctrl       <= '0;
            md_div        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            dz            <= 1'b0;
            out_valid     <= 1'b0;
            result        <= '0;
            store_data    <= '0;
            baddr         <= '0;
            dest_num      <= '0;
            reg_write_out <= 1'b0;
            pc_src        <= 1'b0;
            div_by_zero   <= 1'b0;
            ctrl_out      <= '0;
        end else begin
            if (accept && is_md_op) begin
                cnt      <= '0;
                md_div   <= md_op[2] | (md_op == 3'd3);
                neg_q    <= sa ^ sb;
                neg_r    <= sa;
                dz       <= (rt_data == '0);
                dvd_raw  <= rs_data;
                acc_hi   <= '0;
                acc_lo   <= (md_op >= 3'd3) ? ma : mb;
                mcand    <= (md_op >= 3'd3) ? mb : ma;
                md_store <= rt_data;
                md_dest  <= dest_nx;
                md_ctrl  <= ctrl_in;
            end else if (state == MD) begin
                if (!last) begin
                    acc_hi <= hi_st;
                    acc_lo <= lo_st;
                    cnt    <= cnt + CW'(1);
                end else if (slot_free) begin
                    hi <= fin_hi;
                    lo <= fin_lo;
                end
            end

            if (accept && !is_md_op) begin
                out_valid     <= 1'b1;
                result        <= ex_res;
                store_data    <= rt_data;
                baddr         <= baddr_nx;
                dest_num      <= dest_nx;
                reg_write_out <= reg_write_in;
                pc_src        <= branch && (rs_data == rt_data);
                div_by_zero   <= 1'b0;
                ctrl_out      <= ctrl_in;
            end else if (fire) begin
                out_valid     <= 1'b1;
                result        <= fin_lo;
                store_data    <= md_store;
                baddr         <= '0;
                dest_num      <= md_dest;
                reg_write_out <= 1'b0;
                pc_src        <= 1'b0;
                div_by_zero   <= md_div && dz;
                ctrl_out      <= md_ctrl;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed self-checking bench for ex_stage_md.
// Scenario tasks drive vectors and compare against hand-computed values.
module tb_ex_stage_md;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] rs_data, rt_data, imm, pc4;
    logic [4:0]  shamt;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [2:0]  md_op;
    logic        branch;
    logic [1:0]  dest_sel;
    logic [4:0]  rt_num, rd_num;
    logic        reg_write_in;
    logic [15:0] ctrl_in;
    logic        out_valid, out_ready;
    logic [31:0] result, store_data, baddr;
    logic [4:0]  dest_num;
    logic        reg_write_out, pc_src, div_by_zero;
    logic [15:0] ctrl_out;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_stage_md #(.WIDTH(32), .REGW(5), .CTRL_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs_data(rs_data), .rt_data(rt_data),
        .imm(imm), .pc4(pc4), .shamt(shamt),
        .alu_op(alu_op), .alu_src(alu_src), .md_op(md_op),
        .branch(branch), .dest_sel(dest_sel),
        .rt_num(rt_num), .rd_num(rd_num),
        .reg_write_in(reg_write_in), .ctrl_in(ctrl_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .store_data(store_data), .baddr(baddr),
        .dest_num(dest_num), .reg_write_out(reg_write_out),
        .pc_src(pc_src), .div_by_zero(div_by_zero),
        .ctrl_out(ctrl_out), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        in_valid = 0; rs_data = 0; rt_data = 0; imm = 0; pc4 = 0;
        shamt = 0; alu_op = 0; alu_src = 0; md_op = 0; branch = 0;
        dest_sel = 0; rt_num = 0; rd_num = 0; reg_write_in = 0;
        ctrl_in = 0;
    endtask

    task automatic drive(input logic [3:0] aop, input logic [2:0] mop,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1; alu_op = aop; md_op = mop;
        rs_data = a; rt_data = b;
    endtask

    // Waits for an MD result; cyc reports edges taken (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            cyc++;
            if (out_valid && !busy) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        idle_in();
        out_ready = 1;
        tick();
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_flags got v=%b b=%b r=%b want 0 0 1",
                     out_valid, busy, in_ready);
        end
        total++;
        if (result !== 0 || baddr !== 0 || pc_src !== 0 ||
            div_by_zero !== 0 || ctrl_out !== 0 || dest_num !== 0) begin
            bad++;
            $display("FAIL reset_regs got res=%h baddr=%h pc=%b dz=%b",
                     result, baddr, pc_src, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_back_to_back;
        drive(4'd0, 3'd0, 32'd5, 32'd7);
        dest_sel = 2'b01; rd_num = 5'd3; rt_num = 5'd9;
        reg_write_in = 1; ctrl_in = 16'hA5A5;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready0 got %b want 1", in_ready);
        end
        tick();
        total++;
        if (result !== 32'd12 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL b2b_add got %h v=%b want 0000000c v=1",
                     result, out_valid);
        end
        total++;
        if (dest_num !== 5'd3 || reg_write_out !== 1'b1 ||
            ctrl_out !== 16'hA5A5 || store_data !== 32'd7) begin
            bad++;
            $display("FAIL b2b_fields got d=%h w=%b c=%h s=%h",
                     dest_num, reg_write_out, ctrl_out, store_data);
        end
        drive(4'd1, 3'd0, 32'd3, 32'd5);
        dest_sel = 2'b10; ctrl_in = 16'h1234;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_ready1 got %b want 1", in_ready);
        end
        tick();
        total++;
        if (result !== 32'hFFFFFFFE || out_valid !== 1'b1 ||
            dest_num !== 5'h1F || ctrl_out !== 16'h1234) begin
            bad++;
            $display("FAIL b2b_sub got %h v=%b d=%h c=%h want fffffffe 1 1f 1234",
                     result, out_valid, dest_num, ctrl_out);
        end
        idle_in();
        tick();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_alu_ops;
        logic [3:0]  ops [11] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                  4'd7, 4'd8, 4'd9, 4'd10, 4'd11};
        logic        src [11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        logic [31:0] av  [11] = '{32'd5, 32'h800000F0, 32'h800000F0,
                                  32'h800000F0, 32'h800000F0,
                                  32'h800000F0, 32'h800000F0,
                                  32'd0, 32'd0, 32'd0, 32'd1};
        logic [31:0] bv  [11] = '{32'h10, 32'h00000FF0, 32'h00000FF0,
                                  32'h00000FF0, 32'h00000FF0,
                                  32'h00000FF0, 32'h00000FF0,
                                  32'hF000000F, 32'hF000000F,
                                  32'hF000000F, 32'd1};
        logic [31:0] ex  [11] = '{32'h15, 32'h000000F0, 32'h80000FF0,
                                  32'h80000F00, 32'h7FFFF00F, 32'd1,
                                  32'd0, 32'h000000F0, 32'h0F000000,
                                  32'hFF000000, 32'd0};
        shamt = 5'd4;
        for (int i = 0; i < 11; i++) begin
            drive(ops[i], 3'd0, av[i], src[i] ? 32'h99 : bv[i]);
            alu_src = src[i];
            imm = bv[i];
            tick();
            total++;
            if (result !== ex[i] || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL alu_op%0d got %h v=%b want %h",
                         ops[i], result, out_valid, ex[i]);
            end
        end
        idle_in();
        tick();
    endtask

    task automatic test_branch;
        drive(4'd0, 3'd0, 32'd9, 32'd9);
        branch = 1; pc4 = 32'h100; imm = 32'hFFFFFFFF;
        tick();
        total++;
        if (pc_src !== 1'b1 || baddr !== 32'hFC) begin
            bad++;
            $display("FAIL beq_taken got pc=%b baddr=%h want 1 000000fc",
                     pc_src, baddr);
        end
        rt_data = 32'd8;
        tick();
        total++;
        if (pc_src !== 1'b0 || baddr !== 32'hFC) begin
            bad++;
            $display("FAIL beq_not got pc=%b baddr=%h want 0 000000fc",
                     pc_src, baddr);
        end
        idle_in();
        tick();
    endtask

    task automatic test_mult;
        int cyc;
        logic ok;
        drive(4'd0, 3'd1, 32'hFFFFFFFD, 32'd7);
        dest_sel = 2'b01; rd_num = 5'd4; reg_write_in = 1;
        tick();
        idle_in();
        ok = 1;
        for (int i = 0; i < 31; i++) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) ok = 0;
            tick();
        end
        total++;
        if (ok !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mult_busy_window got ok=%b busy=%b want 1 1",
                     ok, busy);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b0 ||
            result !== 32'hFFFFFFEB) begin
            bad++;
            $display("FAIL mult_done got v=%b b=%b res=%h want 1 0 ffffffeb",
                     out_valid, busy, result);
        end
        total++;
        if (reg_write_out !== 1'b0 || pc_src !== 1'b0 ||
            baddr !== 0 || dest_num !== 5'd4) begin
            bad++;
            $display("FAIL mult_fields got w=%b pc=%b ba=%h d=%h",
                     reg_write_out, pc_src, baddr, dest_num);
        end
        drive(4'd0, 3'd5, 32'd0, 32'd0);
        tick();
        total++;
        if (result !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL mult_mfhi got %h want ffffffff", result);
        end
        drive(4'd0, 3'd6, 32'd0, 32'd0);
        tick();
        total++;
        if (result !== 32'hFFFFFFEB) begin
            bad++;
            $display("FAIL mult_mflo got %h want ffffffeb", result);
        end
        drive(4'd0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        tick();
        idle_in();
        wait_done(cyc);
        total++;
        if (cyc !== 32 || result !== 32'h00000001) begin
            bad++;
            $display("FAIL multu_lo got cyc=%0d res=%h want 32 00000001",
                     cyc, result);
        end
        drive(4'd0, 3'd5, 32'd0, 32'd0);
        tick();
        total++;
        if (result !== 32'hFFFFFFFE) begin
            bad++;
            $display("FAIL multu_hi got %h want fffffffe", result);
        end
        idle_in();
        tick();
    endtask

    task automatic test_div;
        int cyc;
        logic [31:0] a [4] = '{32'hFFFFFFF9, 32'd10, 32'h80000000, 32'd100};
        logic [31:0] b [4] = '{32'd2, 32'd0, 32'hFFFFFFFF, 32'd7};
        logic [2:0]  op [4] = '{3'd3, 3'd4, 3'd3, 3'd4};
        logic [31:0] elo [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF,
                                 32'h80000000, 32'd14};
        logic [31:0] ehi [4] = '{32'hFFFFFFFF, 32'd10, 32'd0, 32'd2};
        logic        edz [4] = '{0, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            drive(4'd0, op[i], a[i], b[i]);
            tick();
            idle_in();
            wait_done(cyc);
            total++;
            if (cyc !== 32 || result !== elo[i] ||
                div_by_zero !== edz[i]) begin
                bad++;
                $display("FAIL div%0d_lo got cyc=%0d lo=%h dz=%b want 32 %h %b",
                         i, cyc, result, div_by_zero, elo[i], edz[i]);
            end
            drive(4'd0, 3'd5, 32'd0, 32'd0);
            tick();
            total++;
            if (result !== ehi[i] || div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL div%0d_hi got %h dz=%b want %h 0",
                         i, result, div_by_zero, ehi[i]);
            end
            idle_in();
            tick();
        end
    endtask

    task automatic test_backpressure;
        logic ok;
        out_ready = 0;
        drive(4'd0, 3'd0, 32'd5, 32'd7);
        ctrl_in = 16'h00C3;
        tick();
        total++;
        if (result !== 32'd12 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_load got %h v=%b want 0000000c 1",
                     result, out_valid);
        end
        drive(4'd1, 3'd0, 32'd3, 32'd5);
        ctrl_in = 16'h0F0F;
        ok = 1;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0) ok = 0;
            tick();
            if (result !== 32'd12 || out_valid !== 1'b1 ||
                ctrl_out !== 16'h00C3 || store_data !== 32'd7) ok = 0;
        end
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold got res=%h v=%b c=%h want 0000000c 1 00c3",
                     result, out_valid, ctrl_out);
        end
        out_ready = 1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        tick();
        total++;
        if (result !== 32'hFFFFFFFE || out_valid !== 1'b1 ||
            ctrl_out !== 16'h0F0F) begin
            bad++;
            $display("FAIL bp_next got %h v=%b want fffffffe 1",
                     result, out_valid);
        end
        idle_in();
        tick();
    endtask

    task automatic test_reset_mid_md;
        drive(4'd0, 3'd1, 32'd1234, 32'd5678);
        tick();
        idle_in();
        repeat (10) tick();
        rst_n = 0;
        #1;
        total++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid got b=%b v=%b r=%b want 0 0 1",
                     busy, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1;
        drive(4'd0, 3'd5, 32'd0, 32'd0);
        tick();
        total++;
        if (result !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_hi got %h want 00000000", result);
        end
        drive(4'd0, 3'd6, 32'd0, 32'd0);
        tick();
        total++;
        if (result !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_lo got %h want 00000000", result);
        end
        drive(4'd0, 3'd0, 32'd5, 32'd7);
        tick();
        total++;
        if (result !== 32'd12 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_add got %h v=%b want 0000000c 1",
                     result, out_valid);
        end
        idle_in();
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alu_ops();
        test_branch();
        test_mult();
        test_div();
        test_backpressure();
        test_reset_mid_md();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the MIPS pipeline, sitting between the ID/EX and EX/MEM boundaries. It adds three things to the plain single-cycle EX: an EX/MEM output register with valid/ready handshaking, an iterative multi-cycle multiply/divide unit with architectural HI/LO registers, and registered branch resolution. Data width and sideband control width are parameters, so one block serves every datapath variant. Sideband control bits (memory/cache/write-back controls) travel through the stage unchanged.

## Interface
- WIDTH, 32: datapath width; must be even and ≥ 8.
- REGW, 5: register-number width.
- CTRL_W, 16: width of the opaque sideband control bundle.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID/EX presents an instruction.
- in_ready  out  1  stage accepts this cycle. Combinational: state==IDLE && (!out_valid || out_ready).
- rs_data, rt_data, imm, pc4  in  WIDTH  operands; imm is already extended by decode.
- shamt  in  5  shift amount.
- alu_op  in  4  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 nor, 6 slt, 7 sltu, 8 sll, 9 srl, 10 sra; any other value gives result 0.
- alu_src  in  1  1 selects imm as operand B; 0 selects rt_data.
- md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo; 7 is treated as 0.
- branch  in  1  beq-type branch.
- dest_sel  in  2  00 rt_num, 01 rd_num, 10 all-ones (ra), 11 rt_num.
- rt_num, rd_num  in  REGW  candidate destination numbers.
- reg_write_in  in  1  write-back enable.
- ctrl_in  in  CTRL_W  sideband bundle.
- out_valid  out  1  EX/MEM register holds a result.
- out_ready  in  1  downstream accepts.
- result, store_data, baddr  out  WIDTH  registered outputs.
- dest_num  out  REGW  registered destination number.
- reg_write_out, pc_src, div_by_zero  out  1  registered flags.
- ctrl_out  out  CTRL_W  registered sideband bundle.
- busy  out  1  high while in the MD state.

## Operation
- States: IDLE and MD. Accept = in_valid && in_ready.
- **Accept, ALU path** (md_op ∈ {0, 5, 6, 7}):
  - Next edge loads the output register and sets out_valid=1.
  - result = ALU result, HI (md_op 5) or LO (md_op 6).
  - store_data = rt_data; ctrl_out = ctrl_in.
  - dest_num is chosen by dest_sel; reg_write_out = reg_write_in.
- **Branch fields** (ALU path only):
  - pc_src = branch && (rs_data == rt_data).
  - baddr = pc4 + (imm << 2), truncated to WIDTH.
  - On the MD path pc_src=0 and baddr=0.
- **Accept, MD path** (md_op 1–4):
  - Operands and controls are latched and the block enters MD.
  - A counter runs WIDTH iterations, one per cycle:
    - multiply: shift-add over 2·WIDTH bits;
    - divide: restoring division.
  - Signed ops work on magnitudes, then negate: the product if operand signs differ; the quotient if signs differ; the remainder takes the dividend's sign.
  - Final iteration edge: writes HI/LO, loads the output register (result=LO, reg_write_out=0, other fields as on the ALU path), sets out_valid=1 and returns to IDLE.
- **Divide by zero**: LO = all-ones, HI = dividend, div_by_zero=1 on that output; otherwise div_by_zero=0.
- **Signed MIN / −1**: LO = MIN, HI = 0.
- **Backpressure**: while out_valid && !out_ready, every output register holds stable. out_valid clears on out_ready unless a new result loads on the same edge.
- **MD completion while the previous result is unconsumed**: cannot happen, because MD is only entered when the output slot will be free. The MD state may still wait on out_ready at the final iteration; the counter holds until the slot frees.
- **mfhi/mflo**: read the committed HI/LO. No hazard exists, because in_ready=0 throughout MD.

## Timing
- Reset (async assert):
  - state=IDLE, counter=0, HI=LO=0.
  - All registered outputs are 0, including out_valid, pc_src, baddr and div_by_zero.
  - busy=0; in_ready=1.
- Reset asserted mid-MD aborts the operation; HI/LO read 0 afterwards.
- ALU latency: accept at edge N → out_valid=1 after edge N. Throughput is 1 per cycle when out_ready=1.
- MD latency: accept at edge N → busy=1 after N through N+WIDTH−1 → out_valid=1 and HI/LO updated after edge N+WIDTH, when out_ready stays 1.
- Back-to-back ALU ops with out_ready=1: in_ready stays 1.

## Test plan
- Reset, then add rs=5 rt=7, then sub 3−5 with out_ready=1 → result=12 then 0xFFFFFFFE on consecutive cycles, out_valid=1 both cycles, in_ready held 1.
- beq rs=rt=9, pc4=0x100, imm=0xFFFFFFFF → pc_src=1, baddr=0xFC. Same with rs≠rt → pc_src=0.
- mult 0xFFFFFFFD × 7, then mfhi, then mflo → busy for 32 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. in_ready=0 throughout MD.
- div −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 10 / 0 → LO=0xFFFFFFFF, HI=10, div_by_zero=1.
- out_ready=0 for 5 cycles with result 12 pending → all outputs stable, in_ready=0. Releasing out_ready → next op accepted the same edge.
- rst_n pulsed low at MD cycle 10 → busy=0, out_valid=0, HI=LO=0 immediately. Next add still correct.
